// File: rtl/wb_bram_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone BRAM arbiter: state encoding,
// one-hot grant codes and the reset level macro used by every register.
`ifndef RstEnable
`define RstEnable 1'b0
`endif

package wb_bram_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_M0   = 2'b01;
   localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/wb_bram_arbiter_if.sv
// Bus bundle for the arbiter: two Wishbone masters (m0 = fetch, m1 = data),
// the BRAM-wrapper slave side and the debug grant vector.
interface wb_bram_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);

   logic              m0_cyc_i;
   logic              m0_stb_i;
   logic              m0_we_i;
   logic [ADDR_W-1:0] m0_adr_i;
   logic [DATA_W-1:0] m0_dat_i;
   logic [3:0]        m0_sel_i;
   logic [DATA_W-1:0] m0_dat_o;
   logic              m0_ack_o;

   logic              m1_cyc_i;
   logic              m1_stb_i;
   logic              m1_we_i;
   logic [ADDR_W-1:0] m1_adr_i;
   logic [DATA_W-1:0] m1_dat_i;
   logic [3:0]        m1_sel_i;
   logic [DATA_W-1:0] m1_dat_o;
   logic              m1_ack_o;

   logic              s_cyc_o;
   logic              s_stb_o;
   logic              s_we_o;
   logic [ADDR_W-1:0] s_adr_o;
   logic [DATA_W-1:0] s_dat_o;
   logic [3:0]        s_sel_o;
   logic [DATA_W-1:0] s_dat_i;
   logic              s_ack_i;

   logic [1:0]        gnt_o;

   // The arbiter is the Wishbone slave of both masters.
   modport slave (
      input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i,
      output m0_dat_o, m0_ack_o,
      input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i,
      output m1_dat_o, m1_ack_o,
      output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
      input  s_dat_i, s_ack_i,
      output gnt_o
   );

   // The surrounding system: both masters plus the BRAM wrapper.
   modport master (
      output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i,
      input  m0_dat_o, m0_ack_o,
      output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i,
      input  m1_dat_o, m1_ack_o,
      input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
      output s_dat_i, s_ack_i,
      input  gnt_o
   );

endinterface

// File: rtl/wb_bram_arbiter_prio.sv
// Combinational grant select for the BRAM arbiter. Fixed priority (m1 over m0)
// by default; round-robin on contention when WB_ARB_ROUND_ROBIN_EN is defined.
module wb_arb_prio
   import wb_bram_arbiter_pkg::*;
(
   input  logic       m0_req,
   input  logic       m1_req,
   input  logic       last_gnt,   // 1 = m1 was granted last
   output logic [1:0] gnt
);

`ifdef WB_ARB_ROUND_ROBIN_EN
   // NOTE: gnt gets a default before any branch so no path leaves it unassigned (no latch).
   always_comb begin
      gnt = GNT_NONE;
      if (m0_req && m1_req) begin
         gnt = last_gnt ? GNT_M0 : GNT_M1;
      end else if (m1_req) begin
         gnt = GNT_M1;
      end else if (m0_req) begin
         gnt = GNT_M0;
      end
   end
`else
   // The pointer only matters for round-robin; keep the port for a uniform interface.
   logic unused_last_gnt;
   assign unused_last_gnt = last_gnt;

   always_comb begin
      gnt = GNT_NONE;
      if (m1_req) begin
         gnt = GNT_M1;
      end else if (m0_req) begin
         gnt = GNT_M0;
      end
   end
`endif

endmodule

// File: rtl/wb_bram_arbiter.sv
// Two-master Wishbone arbiter in front of a single-port BRAM wrapper; sequences
// address, read latency and a one-cycle ack. Optional: WB_ARB_ROUND_ROBIN_EN.
module wb_bram_arbiter
   import wb_bram_arbiter_pkg::*;
#(
   parameter int unsigned RD_LATENCY = 1,
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   wb_bram_arbiter_if.slave bus
);

   localparam logic [1:0] LAT_LOAD = 2'(RD_LATENCY);

   state_e            state_q;
   state_e            state_d;
   logic [1:0]        arb_gnt;
   logic [1:0]        gnt_q;
   logic              m0_req;
   logic              m1_req;
   logic              granted_cyc;
   logic              last_gnt;

   logic [ADDR_W-1:0] lat_adr;
   logic [DATA_W-1:0] lat_dat;
   logic [3:0]        lat_sel;
   logic              lat_we;
   logic [1:0]        cnt_q;
   logic [DATA_W-1:0] m0_dat_q;
   logic [DATA_W-1:0] m1_dat_q;

   assign m0_req = bus.m0_cyc_i & bus.m0_stb_i;
   assign m1_req = bus.m1_cyc_i & bus.m1_stb_i;

   // Only the owner's cyc matters once granted; losing it aborts the access.
   assign granted_cyc = (gnt_q[0] & bus.m0_cyc_i) | (gnt_q[1] & bus.m1_cyc_i);

   wb_arb_prio u_prio (
      .m0_req   (m0_req),
      .m1_req   (m1_req),
      .last_gnt (last_gnt),
      .gnt      (arb_gnt)
   );

`ifdef WB_ARB_ROUND_ROBIN_EN
   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (wb_rst_i == `RstEnable) begin
         last_gnt <= 1'b0;
      end else if (state_q == IDLE && arb_gnt != GNT_NONE) begin
         last_gnt <= arb_gnt[1];
      end
   end
`else
   assign last_gnt = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (wb_rst_i == `RstEnable) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (arb_gnt != GNT_NONE) begin
               state_d = ADDR;
            end
         end
         ADDR: begin
            if (!granted_cyc) begin
               state_d = IDLE;
            end else if (bus.s_ack_i) begin
               state_d = lat_we ? DONE : WAIT;
            end
         end
         WAIT: begin
            if (!granted_cyc) begin
               state_d = IDLE;
            end else if (cnt_q == 2'd1) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (wb_rst_i == `RstEnable) begin
         gnt_q    <= GNT_NONE;
         lat_adr  <= '0;
         lat_dat  <= '0;
         lat_sel  <= '0;
         lat_we   <= 1'b0;
         cnt_q    <= 2'd0;
         m0_dat_q <= '0;
         m1_dat_q <= '0;
      end else begin
         if (state_q == IDLE && arb_gnt != GNT_NONE) begin
            if (arb_gnt == GNT_M1) begin
               lat_adr <= bus.m1_adr_i;
               lat_dat <= bus.m1_dat_i;
               lat_sel <= bus.m1_sel_i;
               lat_we  <= bus.m1_we_i;
            end else begin
               lat_adr <= bus.m0_adr_i;
               lat_dat <= bus.m0_dat_i;
               lat_sel <= bus.m0_sel_i;
               lat_we  <= bus.m0_we_i;
            end
         end

         // Grant is held from ADDR through DONE and dropped on any return to IDLE.
         if (state_d == IDLE) begin
            gnt_q <= GNT_NONE;
         end else if (state_q == IDLE) begin
            gnt_q <= arb_gnt;
         end

         if (state_d == IDLE) begin
            cnt_q <= 2'd0;
         end else if (state_q == ADDR && state_d == WAIT) begin
            cnt_q <= LAT_LOAD;
         end else if (state_q == WAIT) begin
            cnt_q <= cnt_q - 2'd1;
         end

         // Capture only on a completed read; an aborted one leaves the old data visible.
         if (state_q == WAIT && state_d == DONE) begin
            if (gnt_q[0]) begin
               m0_dat_q <= bus.s_dat_i;
            end
            if (gnt_q[1]) begin
               m1_dat_q <= bus.s_dat_i;
            end
         end
      end
   end

   always_comb begin
      bus.s_cyc_o  = 1'b0;
      bus.s_stb_o  = 1'b0;
      bus.s_we_o   = 1'b0;
      bus.s_adr_o  = '0;
      bus.s_dat_o  = '0;
      bus.s_sel_o  = '0;
      bus.m0_ack_o = 1'b0;
      bus.m1_ack_o = 1'b0;
      case (state_q)
         ADDR: begin
            bus.s_cyc_o = 1'b1;
            bus.s_stb_o = 1'b1;
            bus.s_we_o  = lat_we;
            bus.s_adr_o = lat_adr;
            bus.s_dat_o = lat_dat;
            bus.s_sel_o = lat_sel;
         end
         WAIT: begin
            bus.s_cyc_o = 1'b1;
            bus.s_adr_o = lat_adr;
         end
         DONE: begin
            bus.m0_ack_o = gnt_q[0];
            bus.m1_ack_o = gnt_q[1];
         end
         default: begin
         end
      endcase
      bus.m0_dat_o = m0_dat_q;
      bus.m1_dat_o = m1_dat_q;
      bus.gnt_o    = gnt_q;
   end

endmodule

// File: tb/tb_wb_bram_arbiter.sv
// Directed bench for wb_bram_arbiter: a RD_LATENCY=1 instance carries most steps,
// a RD_LATENCY=3 instance checks the longer wait; each BRAM is a small model.
module tb_wb_bram_arbiter;
   import wb_bram_arbiter_pkg::*;

`ifdef WB_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif
   localparam logic [31:0] POISON = 32'hBAD0_BAD0;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   wb_bram_arbiter_if bus  ();
   wb_bram_arbiter_if bus3 ();

   wb_bram_arbiter #(.RD_LATENCY(1), .ADDR_W(32), .DATA_W(32)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst_n),
      .bus      (bus)
   );

   wb_bram_arbiter #(.RD_LATENCY(3), .ADDR_W(32), .DATA_W(32)) dut3 (
      .wb_clk_i (clk),
      .wb_rst_i (rst_n),
      .bus      (bus3)
   );

   // BRAM models: combinational ack, read data valid exactly RD_LATENCY cycles after the address.
   logic [31:0] mem1 [256] = '{4: 32'hDEAD_BEEF, 12: 32'hCAFE_F00D, default: 32'h0};
   logic [31:0] mem3 [256] = '{4: 32'hDEAD_BEEF, default: 32'h0};
   logic [31:0] pipe1;
   logic [31:0] p3a, p3b, p3c;

   assign bus.s_ack_i  = bus.s_cyc_o & bus.s_stb_o;
   assign bus.s_dat_i  = pipe1;
   assign bus3.s_ack_i = bus3.s_cyc_o & bus3.s_stb_o;
   assign bus3.s_dat_i = p3c;

   always @(posedge clk) begin
      if (bus.s_cyc_o && bus.s_stb_o && bus.s_we_o) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.s_sel_o[b]) mem1[bus.s_adr_o[9:2]][8*b +: 8] <= bus.s_dat_o[8*b +: 8];
         end
      end
      pipe1 <= (bus.s_cyc_o && bus.s_stb_o && !bus.s_we_o) ? mem1[bus.s_adr_o[9:2]] : POISON;
   end

   always @(posedge clk) begin
      p3a <= (bus3.s_cyc_o && bus3.s_stb_o && !bus3.s_we_o) ? mem3[bus3.s_adr_o[9:2]] : POISON;
      p3b <= p3a;
      p3c <= p3b;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic m0_set(input logic req, input logic we, input logic [31:0] adr, input logic [31:0] dat);
      bus.m0_cyc_i = req;
      bus.m0_stb_i = req;
      bus.m0_we_i  = we;
      bus.m0_adr_i = adr;
      bus.m0_dat_i = dat;
      bus.m0_sel_i = 4'hF;
   endtask

   task automatic m1_set(input logic req, input logic we, input logic [31:0] adr, input logic [31:0] dat);
      bus.m1_cyc_i = req;
      bus.m1_stb_i = req;
      bus.m1_we_i  = we;
      bus.m1_adr_i = adr;
      bus.m1_dat_i = dat;
      bus.m1_sel_i = 4'hF;
   endtask

   initial begin
      m0_set(1'b0, 1'b0, 32'h0, 32'h0);
      m1_set(1'b0, 1'b0, 32'h0, 32'h0);
      bus3.m0_cyc_i = 1'b0; bus3.m0_stb_i = 1'b0; bus3.m0_we_i = 1'b0;
      bus3.m0_adr_i = '0;   bus3.m0_dat_i = '0;   bus3.m0_sel_i = 4'h0;
      bus3.m1_cyc_i = 1'b0; bus3.m1_stb_i = 1'b0; bus3.m1_we_i = 1'b0;
      bus3.m1_adr_i = '0;   bus3.m1_dat_i = '0;   bus3.m1_sel_i = 4'h0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_s_cyc", 32'(bus.s_cyc_o), 32'd0);
      check("rst_s_stb", 32'(bus.s_stb_o), 32'd0);
      check("rst_s_adr", bus.s_adr_o, 32'h0);
      check("rst_gnt", 32'(bus.gnt_o), 32'(GNT_NONE));
      check("rst_m0_ack", 32'(bus.m0_ack_o), 32'd0);
      check("rst_m1_ack", 32'(bus.m1_ack_o), 32'd0);
      check("rst_m1_dat", bus.m1_dat_o, 32'h0);
      check("rst3_gnt", 32'(bus3.gnt_o), 32'(GNT_NONE));
      rst_n = 1'b1;
      @(negedge clk);

      // m1 reads word 4 alone
      m1_set(1'b1, 1'b0, 32'h10, 32'h0);
      check("t1_c0_gnt", 32'(bus.gnt_o), 32'(GNT_NONE));
      @(negedge clk);
      check("t1_c1_stb", 32'(bus.s_stb_o), 32'd1);
      check("t1_c1_adr", bus.s_adr_o, 32'h10);
      check("t1_c1_we", 32'(bus.s_we_o), 32'd0);
      check("t1_c1_gnt", 32'(bus.gnt_o), 32'(GNT_M1));
      check("t1_c1_ack", 32'(bus.m1_ack_o), 32'd0);
      @(negedge clk);
      check("t1_c2_stb", 32'(bus.s_stb_o), 32'd0);
      check("t1_c2_cyc", 32'(bus.s_cyc_o), 32'd1);
      check("t1_c2_adr", bus.s_adr_o, 32'h10);
      check("t1_c2_ack", 32'(bus.m1_ack_o), 32'd0);
      @(negedge clk);
      check("t1_c3_ack", 32'(bus.m1_ack_o), 32'd1);
      check("t1_c3_dat", bus.m1_dat_o, 32'hDEAD_BEEF);
      check("t1_c3_m0ack", 32'(bus.m0_ack_o), 32'd0);
      m1_set(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      check("t1_c4_ack", 32'(bus.m1_ack_o), 32'd0);
      check("t1_c4_gnt", 32'(bus.gnt_o), 32'(GNT_NONE));
      check("t1_c4_cyc", 32'(bus.s_cyc_o), 32'd0);
      check("t1_c4_dat", bus.m1_dat_o, 32'hDEAD_BEEF);

      // m0 writes 0x20, then reads it back
      m0_set(1'b1, 1'b1, 32'h20, 32'h1234_5678);
      @(negedge clk);
      check("t2_c1_we", 32'(bus.s_we_o), 32'd1);
      check("t2_c1_adr", bus.s_adr_o, 32'h20);
      check("t2_c1_dat", bus.s_dat_o, 32'h1234_5678);
      check("t2_c1_gnt", 32'(bus.gnt_o), 32'(GNT_M0));
      check("t2_c1_ack", 32'(bus.m0_ack_o), 32'd0);
      @(negedge clk);
      check("t2_c2_ack", 32'(bus.m0_ack_o), 32'd1);
      check("t2_c2_m1ack", 32'(bus.m1_ack_o), 32'd0);
      m0_set(1'b1, 1'b0, 32'h20, 32'h0);
      @(negedge clk);
      check("t2_c3_ack", 32'(bus.m0_ack_o), 32'd0);
      check("t2_c3_cyc", 32'(bus.s_cyc_o), 32'd0);
      repeat (3) @(negedge clk);
      check("t2_rd_ack", 32'(bus.m0_ack_o), 32'd1);
      check("t2_rd_dat", bus.m0_dat_o, 32'h1234_5678);
      m0_set(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);

      // Both masters read continuously
      m0_set(1'b1, 1'b0, 32'h20, 32'h0);
      m1_set(1'b1, 1'b0, 32'h10, 32'h0);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         check($sformatf("t3_c%0d_m1ack", c), 32'(bus.m1_ack_o),
               32'((c == 3) || (c == 11) || (c == 7 && !RR)));
         check($sformatf("t3_c%0d_m0ack", c), 32'(bus.m0_ack_o), 32'(c == 7 && RR));
         if (c == 11) begin
            m0_set(1'b0, 1'b0, 32'h0, 32'h0);
            m1_set(1'b0, 1'b0, 32'h0, 32'h0);
         end
      end
      @(negedge clk);
      check("t3_m1_dat", bus.m1_dat_o, 32'hDEAD_BEEF);
      check("t3_m0_dat", bus.m0_dat_o, 32'h1234_5678);
      check("t3_gnt", 32'(bus.gnt_o), 32'(GNT_NONE));

      // m1 read aborted in WAIT, pending m0 read served next
      m1_set(1'b1, 1'b0, 32'h30, 32'h0);
      @(negedge clk);
      check("t4_c1_gnt", 32'(bus.gnt_o), 32'(GNT_M1));
      m0_set(1'b1, 1'b0, 32'h20, 32'h0);
      @(negedge clk);
      check("t4_c2_cyc", 32'(bus.s_cyc_o), 32'd1);
      check("t4_c2_stb", 32'(bus.s_stb_o), 32'd0);
      m1_set(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      check("t4_c3_cyc", 32'(bus.s_cyc_o), 32'd0);
      check("t4_c3_gnt", 32'(bus.gnt_o), 32'(GNT_NONE));
      check("t4_c3_m1ack", 32'(bus.m1_ack_o), 32'd0);
      @(negedge clk);
      check("t4_c4_gnt", 32'(bus.gnt_o), 32'(GNT_M0));
      check("t4_c4_adr", bus.s_adr_o, 32'h20);
      check("t4_c4_m1dat", bus.m1_dat_o, 32'hDEAD_BEEF);
      repeat (2) @(negedge clk);
      check("t4_c6_m0ack", 32'(bus.m0_ack_o), 32'd1);
      check("t4_c6_m1ack", 32'(bus.m1_ack_o), 32'd0);
      check("t4_c6_m0dat", bus.m0_dat_o, 32'h1234_5678);
      m0_set(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);

      // Reset pulled during ADDR of an m0 write
      m0_set(1'b1, 1'b1, 32'h40, 32'hAAAA_5555);
      @(negedge clk);
      check("t5_c1_stb", 32'(bus.s_stb_o), 32'd1);
      rst_n = 1'b0;
      #1;
      check("t5_rst_cyc", 32'(bus.s_cyc_o), 32'd0);
      check("t5_rst_stb", 32'(bus.s_stb_o), 32'd0);
      check("t5_rst_we", 32'(bus.s_we_o), 32'd0);
      check("t5_rst_adr", bus.s_adr_o, 32'h0);
      check("t5_rst_sdat", bus.s_dat_o, 32'h0);
      check("t5_rst_gnt", 32'(bus.gnt_o), 32'(GNT_NONE));
      check("t5_rst_m0dat", bus.m0_dat_o, 32'h0);
      check("t5_rst_m1dat", bus.m1_dat_o, 32'h0);
      m0_set(1'b0, 1'b0, 32'h0, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check($sformatf("t5_post%0d_ack", c), 32'(bus.m0_ack_o), 32'd0);
         check($sformatf("t5_post%0d_cyc", c), 32'(bus.s_cyc_o), 32'd0);
      end

      // RD_LATENCY = 3 instance, m1 read of word 4
      bus3.m1_cyc_i = 1'b1; bus3.m1_stb_i = 1'b1; bus3.m1_we_i = 1'b0;
      bus3.m1_adr_i = 32'h10; bus3.m1_sel_i = 4'hF;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         check($sformatf("t6_c%0d_stb", c), 32'(bus3.s_stb_o), 32'(c == 1));
         check($sformatf("t6_c%0d_cyc", c), 32'(bus3.s_cyc_o), 32'(c <= 4));
         check($sformatf("t6_c%0d_ack", c), 32'(bus3.m1_ack_o), 32'(c == 5));
         if (c == 5) begin
            bus3.m1_cyc_i = 1'b0;
            bus3.m1_stb_i = 1'b0;
         end
      end
      check("t6_dat", bus3.m1_dat_o, 32'hDEAD_BEEF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_bram_arbiter.md
Name: wb_bram_arbiter

Overview:
- Two-master Wishbone arbiter in front of the single-port BRAM wrapper.
- Shares the BRAM between the instruction-fetch bus (m0) and the data bus (m1).
- The BRAM wrapper acks combinationally, but BRAM read data arrives RD_LATENCY cycles after the address. This block therefore sequences each access: it presents the address, waits out the read latency, captures the data, and returns a registered one-cycle ack to the granted master.

Parameters:
- RD_LATENCY, 1, BRAM read latency in cycles after the address cycle; legal range 1..3.
- ADDR_W, 32, Wishbone address width.
- DATA_W, 32, Wishbone data width.

Ports:
- wb_clk_i  in  1  clock; all logic on the rising edge.
- wb_rst_i  in  1  asynchronous, active-low reset (`RstEnable = 0).
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  instruction-master cycle, strobe, write enable.
- m0_adr_i  in  ADDR_W  m0 address.
- m0_dat_i  in  DATA_W  m0 write data.
- m0_sel_i  in  4  m0 byte selects.
- m0_dat_o  out  DATA_W  m0 read data.
- m0_ack_o  out  1  m0 ack.
- m1_* (cyc, stb, we, adr, dat_i, sel, dat_o, ack)  same widths and directions as m0_*  data master.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to the BRAM wrapper.
- s_adr_o  out  ADDR_W  to the BRAM wrapper.
- s_dat_o  out  DATA_W  to the BRAM wrapper.
- s_sel_o  out  4  to the BRAM wrapper.
- s_dat_i  in  DATA_W  BRAM read data.
- s_ack_i  in  1  wrapper ack (combinational cyc&stb).
- gnt_o  out  2  one-hot current grant (debug/perf).

Behaviour:
- Reset values: all outputs 0; state IDLE; latency counter 0; data register 0; last-grant pointer = m0.
- Request: mX_req = mX_cyc_i & mX_stb_i.
- States:
  - IDLE: arbitrate.
    - Fixed priority: m1 over m0.
    - Latch the winner's adr/dat/sel/we into registers, set gnt_o, go to ADDR.
    - No request: stay in IDLE, gnt_o = 0.
  - ADDR:
    - Drive s_cyc_o = s_stb_o = 1, s_we_o = latched we, plus latched adr/dat/sel.
    - On s_ack_i: write goes to DONE; read loads counter = RD_LATENCY and goes to WAIT.
    - No s_ack_i: stay in ADDR.
  - WAIT:
    - s_cyc_o = 1, s_stb_o = 0, s_we_o = 0; s_adr_o held.
    - Counter decrements each cycle.
    - On the cycle the counter is 1: capture s_dat_i into the data register, go to DONE.
  - DONE:
    - Assert the granted mX_ack_o for exactly one cycle.
    - mX_dat_o = data register (reads); unchanged for writes.
    - Go to IDLE; gnt_o cleared on exit.
- Latency (RD_LATENCY = 1), request seen in IDLE at cycle 0:
  - Write: ADDR at cycle 1, ack at cycle 2.
  - Read: ADDR at cycle 1, WAIT at cycle 2 (capture), ack at cycle 3.
- Back-to-back: one IDLE cycle between transactions, so maximum throughput is one access per 3 cycles (write) or 4 cycles (read).
- Held request: the master must hold stb until ack. A held request is re-arbitrated in the IDLE after DONE, so it can be served again.
- Abort: granted master drops cyc in ADDR or WAIT → return to IDLE next cycle, no ack. A write already acked by the slave is not undone.
- Simultaneous requests in IDLE: the priority rule decides. The loser keeps waiting and is never acked spuriously.
- Non-granted master: mX_ack_o = 0 at all times; mX_dat_o holds its last value.
- Reset asserted mid-transfer: immediate return to reset values; the in-flight ack is dropped.

Optional Feature:
- Macro: WB_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. On contention in IDLE, the master not granted last wins. The last-grant pointer updates on entry to ADDR.
- Undefined: fixed priority, m1 over m0. The last-grant pointer is not implemented.

Decomposition:
- Shared package / defines:
  - State encoding: IDLE = 2'd0, ADDR = 2'd1, WAIT = 2'd2, DONE = 2'd3.
  - Grant constants: GNT_NONE = 2'b00, GNT_M0 = 2'b01, GNT_M1 = 2'b10.
  - Reuse `RstEnable.
- Sub-module: wb_arb_prio, the combinational grant select.
  - Inputs: two requests, last-grant pointer.
  - Output: one-hot grant.
  - This isolates the fixed/round-robin choice.

Test Plan:
- m1 read 0x0000_0010 alone, BRAM word 4 = 0xDEAD_BEEF, RD_LATENCY = 1 → m1_ack_o high at cycle 3 only, m1_dat_o = 0xDEAD_BEEF, s_stb_o high only at cycle 1.
- m0 write 0x0000_0020, data 0x1234_5678 → s_we_o = 1 and s_adr_o = 0x20 at cycle 1, m0_ack_o at cycle 2; a following m0 read of 0x20 returns 0x1234_5678.
- m0 and m1 both request reads continuously:
  - Fixed priority: m1 is acked every 4 cycles and m0 never.
  - With WB_ARB_ROUND_ROBIN_EN: acks alternate m1, m0, m1, m0.
- m1 read; m1_cyc_i dropped during WAIT → no m1_ack_o, state IDLE next cycle, a pending m0 request is granted the cycle after.
- wb_rst_i pulled low during ADDR of an m0 write → all outputs 0 immediately, gnt_o = 0, no ack after release.
- RD_LATENCY = 3, m1 read → WAIT lasts 3 cycles, data captured in the third, ack at cycle 5.
